// File: rtl/fsm_painter_pkg.sv
// Shared state encoding and width helpers for the fsm_painter controller and its helpers.
package fsm_painter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Index width for a range of n values; never below one bit so ports stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned clr_cnt_w(input int unsigned w, input int unsigned h);
        return idx_w(w * h);
    endfunction

endpackage

// File: rtl/fsm_painter_game_tick_gen.sv
// Free-running game tick: counts 0..TICK_DIV-1 and pulses tick for one cycle at the top count.
module game_tick_gen
    import fsm_painter_pkg::*;
#(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = idx_w(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("game_tick_gen: TICK_DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fsm_painter.sv
// Push-button pixel painter: moves a cursor and paints on game ticks, or sweep-clears the frame buffer.
// Define FSM_PAINTER_WRAP_EN to make the cursor wrap at the grid edges instead of saturating.
module fsm_painter
    import fsm_painter_pkg::*;
#(
    parameter int unsigned   AW       = 8,
    parameter int unsigned   DW       = 3,
    parameter int unsigned   SCREEN_W = 16,
    parameter int unsigned   SCREEN_H = 16,
    parameter int unsigned   TICK_DIV = 500000,
    parameter logic [DW-1:0] BG_COLOR = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_right,
    input  logic                          btn_left,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_paint,
    input  logic                          btn_clear,
    input  logic [DW-1:0]                 color_sel,
    output logic [AW-1:0]                 mem_px_addr,
    output logic [DW-1:0]                 mem_px_data,
    output logic                          px_wr,
    output logic [idx_w(SCREEN_W)-1:0]    cursor_x,
    output logic [idx_w(SCREEN_H)-1:0]    cursor_y,
    output logic                          busy
);

    localparam int unsigned XW = idx_w(SCREEN_W);
    localparam int unsigned YW = idx_w(SCREEN_H);
    localparam int unsigned CW = clr_cnt_w(SCREEN_W, SCREEN_H);

    localparam logic [XW-1:0] X_MAX   = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(SCREEN_H - 1);
    localparam logic [CW-1:0] PX_LAST = CW'(SCREEN_W * SCREEN_H - 1);
    localparam logic [AW:0]   ROW_LEN = (AW + 1)'(SCREEN_W);

    if (longint'(SCREEN_W) * longint'(SCREEN_H) > (longint'(1) << AW)) begin : g_bad_geom
        $error("fsm_painter: SCREEN_W*SCREEN_H does not fit in 2**AW addresses");
    end

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, nx;
    logic [YW-1:0] y_q, y_d, ny;
    logic [AW-1:0] addr_q, addr_d, paint_addr;
    logic [DW-1:0] data_q, data_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;
    logic          tick;

    game_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Opposing buttons cancel; edge behaviour selects wrap or saturate.
    always_comb begin
        nx = x_q;
        if (btn_right && !btn_left) begin
            if (x_q == X_MAX) begin
`ifdef FSM_PAINTER_WRAP_EN
                nx = '0;
`else
                nx = x_q;
`endif
            end else begin
                nx = x_q + XW'(1);
            end
        end else if (btn_left && !btn_right) begin
            if (x_q == '0) begin
`ifdef FSM_PAINTER_WRAP_EN
                nx = X_MAX;
`else
                nx = x_q;
`endif
            end else begin
                nx = x_q - XW'(1);
            end
        end
    end

    always_comb begin
        ny = y_q;
        if (btn_down && !btn_up) begin
            if (y_q == Y_MAX) begin
`ifdef FSM_PAINTER_WRAP_EN
                ny = '0;
`else
                ny = y_q;
`endif
            end else begin
                ny = y_q + YW'(1);
            end
        end else if (btn_up && !btn_down) begin
            if (y_q == '0) begin
`ifdef FSM_PAINTER_WRAP_EN
                ny = Y_MAX;
`else
                ny = y_q;
`endif
            end else begin
                ny = y_q - YW'(1);
            end
        end
    end

    assign paint_addr = AW'((AW + 1)'(ny) * ROW_LEN + (AW + 1)'(nx));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (btn_clear) begin
                        state_d = ST_CLEAR;
                        addr_d  = '0;
                        data_d  = BG_COLOR;
                        wr_d    = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        x_d = nx;
                        y_d = ny;
                        if (btn_paint) begin
                            wr_d   = 1'b1;
                            addr_d = paint_addr;
                            data_d = color_sel;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                // Ticks and buttons are deliberately ignored for the whole sweep.
                if (CW'(addr_q) == PX_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    addr_d = AW'((AW + 1)'(addr_q) + (AW + 1)'(1));
                    wr_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
        end
    end

    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign px_wr       = wr_q;
    assign cursor_x    = x_q;
    assign cursor_y    = y_q;
    assign busy        = busy_q;

endmodule
